// File: rtl/fp180b_pkg.sv
// Shared types and constants for the fp_180b datapath:
// sequencer state encoding, special opcodes and field widths.
package fp180b_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 6;

    localparam logic [OPC_W-1:0] OP_LUI = 6'd10;
    localparam logic [OPC_W-1:0] OP_NW0 = 6'd13;
    localparam logic [OPC_W-1:0] OP_NW1 = 6'd14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_READ,
        ST_ISSUE,
        ST_RESULT,
        ST_WRITE,
        ST_RETIRE
    } seq_state_e;

    function automatic logic is_nowrite(input logic [OPC_W-1:0] op);
        return (op == OP_NW0) || (op == OP_NW1);
    endfunction

endpackage

// File: rtl/rf_wb_fmt.sv
// Writeback data formatting: upper-half loads carry only the
// low 16 result bits, no-write opcodes present zero.
module rf_wb_fmt
    import fp180b_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [DATA_W-1:0] res_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = res_i;
        if (is_nowrite(opcode_i)) begin
            data_o = '0;
        end else if (opcode_i == OP_LUI) begin
            data_o = {16'h0, res_i[15:0]};
        end
    end

endmodule

// File: rtl/rf_sequencer.sv
// Register-file sequencer: drives the RF set/wrt/done handshake
// and moves operands and results to and from execute.
module rf_sequencer
    import fp180b_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rz,
    input  logic [REG_W-1:0]  ry,
    input  logic [REG_W-1:0]  rx,
    output logic              rf_set,
    output logic              rf_wrt,
    output logic [OPC_W-1:0]  rf_opcode,
    output logic [REG_W-1:0]  rf_rz,
    output logic [REG_W-1:0]  rf_ry,
    output logic [REG_W-1:0]  rf_rx,
    output logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] rf_x,
    input  logic [DATA_W-1:0] rf_y,
    input  logic              rf_done,
    output logic              opnd_valid,
    input  logic              opnd_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [OPC_W-1:0]  opc_q;
    logic [REG_W-1:0]  rz_q, ry_q, rx_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, wb_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              tmo;

    assign tmo = (tmr_q == TMR_LAST) && !rf_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (inst_valid) state_d = ST_SET;
            ST_SET:    state_d = ST_READ;
            ST_READ:   state_d = ST_ISSUE;
            ST_ISSUE:  if (opnd_ready) state_d = ST_RESULT;
            ST_RESULT: if (res_valid) state_d = ST_WRITE;
            ST_WRITE:  if (rf_done || tmo) state_d = ST_RETIRE;
            ST_RETIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_ready = 1'b0;
        rf_set     = 1'b0;
        rf_wrt     = 1'b0;
        opnd_valid = 1'b0;
        res_ready  = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            ST_IDLE:   inst_ready = !rst;
            ST_SET:    rf_set     = 1'b1;
            ST_ISSUE:  opnd_valid = 1'b1;
            ST_RESULT: res_ready  = 1'b1;
            ST_WRITE:  rf_wrt     = !is_nowrite(opc_q);
            ST_RETIRE: retire     = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opc_q  <= '0;
            rz_q   <= '0;
            ry_q   <= '0;
            rx_q   <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            wb_q   <= '0;
            tmr_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && inst_valid) begin
                opc_q <= opcode;
                rz_q  <= rz;
                ry_q  <= ry;
                rx_q  <= rx;
            end
            if (state_q == ST_READ) begin
                op_a_q <= rf_x;
                op_b_q <= rf_y;
            end
            if (state_q == ST_RESULT && res_valid) begin
                wb_q <= res_data;
            end
            // Timer only runs while waiting for rf_done.
            if (state_q == ST_WRITE) begin
                tmr_q <= tmr_q + 1'b1;
            end else begin
                tmr_q <= '0;
            end
            if (state_q == ST_WRITE && tmo) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_RETIRE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    rf_wb_fmt u_fmt (
        .opcode_i (opc_q),
        .res_i    (wb_q),
        .data_o   (rf_data)
    );

    assign rf_opcode  = opc_q;
    assign rf_rz      = rz_q;
    assign rf_ry      = ry_q;
    assign rf_rx      = rx_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign retire_cnt = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: RF model plus execute stub, expected
// responses queued by the driver and checked by a monitor.
module tb_rf_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [5:0]  opcode = '0;
    logic [4:0]  rz = '0, ry = '0, rx = '0;
    logic        rf_set, rf_wrt;
    logic [5:0]  rf_opcode;
    logic [4:0]  rf_rz, rf_ry, rf_rx;
    logic [31:0] rf_data, rf_x, rf_y;
    logic        rf_done;
    logic        opnd_valid;
    logic        opnd_ready = 1'b0;
    logic [31:0] op_a, op_b;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res_data = '0;
    logic        retire;
    logic [15:0] retire_cnt;
    logic        err;

    logic        done_en = 1'b1;
    logic        rf_clear = 1'b1;
    logic [31:0] mem [32];

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic        wrt;
        logic [31:0] data;
        logic        done;
        int          lat;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t q[$];
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    rf_sequencer #(.TIMEOUT(15), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .opcode     (opcode),
        .rz         (rz),
        .ry         (ry),
        .rx         (rx),
        .rf_set     (rf_set),
        .rf_wrt     (rf_wrt),
        .rf_opcode  (rf_opcode),
        .rf_rz      (rf_rz),
        .rf_ry      (rf_ry),
        .rf_rx      (rf_rx),
        .rf_data    (rf_data),
        .rf_x       (rf_x),
        .rf_y       (rf_y),
        .rf_done    (rf_done),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .retire     (retire),
        .retire_cnt (retire_cnt),
        .err        (err)
    );

    // RF model: register 0 discards writes, opcode 10 fills the upper half.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (rf_wrt && rf_rz != 5'd0) begin
            if (rf_opcode == 6'd10) mem[rf_rz][31:16] <= rf_data[15:0];
            else mem[rf_rz] <= rf_data;
        end
    end
    assign rf_x = mem[rf_rx];
    assign rf_y = mem[rf_ry];
    assign rf_done = done_en & ~rf_set;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    // Monitor
    initial begin
        int   cyc;
        int   acc_cyc;
        logic wrt_any;
        logic prev_done;
        logic [31:0] prev_data;
        exp_t e;
        cyc = 0; acc_cyc = 0; wrt_any = 1'b0;
        prev_done = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (inst_valid && inst_ready) begin
                    acc_cyc = cyc;
                    wrt_any = 1'b0;
                end
                if (rf_wrt) wrt_any = 1'b1;
                if (opnd_valid) begin
                    if (q.size() == 0) begin
                        check("opnd_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("op_a", op_a, q[0].opa);
                        check("op_b", op_b, q[0].opb);
                    end
                end
                if (retire) begin
                    if (q.size() == 0) begin
                        check("retire_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                        check("rf_wrt", {31'd0, wrt_any}, {31'd0, e.wrt});
                        check("rf_data", prev_data, e.data);
                        check("rf_done", {31'd0, prev_done}, {31'd0, e.done});
                        check("retire_cnt", {16'd0, retire_cnt}, {16'd0, e.cnt});
                        check("err", {31'd0, err}, {31'd0, e.err});
                    end
                end
            end
            prev_data = rf_data;
            prev_done = rf_done;
        end
    end

    task automatic wait_neg(input int sel, input string nm);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = inst_ready;
                1: hit = opnd_valid;
                2: hit = res_ready;
                default: hit = retire;
            endcase
        end
        if (!hit) check({"timeout_", nm}, 32'd0, 32'd1);
    endtask

    task automatic front(input logic [5:0] op, input logic [4:0] z,
                         input logic [4:0] y, input logic [4:0] x,
                         input int dly);
        opcode = op; rz = z; ry = y; rx = x;
        inst_valid = 1'b1;
        wait_neg(0, "accept");
        @(posedge clk); #1;
        inst_valid = 1'b0;
        wait_neg(1, "opnd");
        repeat (dly) @(negedge clk);
        opnd_ready = 1'b1;
        @(posedge clk); #1;
        opnd_ready = 1'b0;
    endtask

    task automatic run(input logic [5:0] op, input logic [4:0] z,
                       input logic [4:0] y, input logic [4:0] x,
                       input logic [31:0] res, input int dly,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic ew, input logic [31:0] ed,
                       input logic edn, input int lat, input logic eerr);
        exp_t e;
        e = '{ea, eb, ew, ed, edn, lat, exp_cnt, eerr};
        q.push_back(e);
        exp_cnt++;
        front(op, z, y, x, dly);
        res_valid = 1'b1;
        res_data = res;
        wait_neg(2, "result");
        @(posedge clk); #1;
        res_valid = 1'b0;
        wait_neg(3, "retire");
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
        check("rst_rf_set", {31'd0, rf_set}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rf_clear = 1'b0;
        @(negedge clk);
        check("idle_inst_ready", {31'd0, inst_ready}, 32'd1);
        check("idle_cnt", {16'd0, retire_cnt}, 32'd0);
        check("idle_err", {31'd0, err}, 32'd0);
        check("idle_op_a", op_a, 32'd0);
        @(posedge clk); #1;

        run(6'd0, 5'd3, 5'd0, 5'd0, 32'hDEADBEEF, 0,
            32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 6, 1'b0);
        check("cnt_after_first", {16'd0, retire_cnt}, 32'd1);
        run(6'd0, 5'd5, 5'd0, 5'd3, 32'h00000001, 0,
            32'hDEADBEEF, 32'h0, 1'b1, 32'h1, 1'b1, 6, 1'b0);
        run(6'd10, 5'd7, 5'd0, 5'd0, 32'h12345678, 0,
            32'h0, 32'h0, 1'b1, 32'h00005678, 1'b1, 6, 1'b0);
        run(6'd13, 5'd5, 5'd7, 5'd7, 32'hCAFEF00D, 0,
            32'h56780000, 32'h56780000, 1'b0, 32'h0, 1'b1, 6, 1'b0);
        run(6'd14, 5'd9, 5'd3, 5'd5, 32'hAAAA5555, 0,
            32'h1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 6, 1'b0);
        run(6'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 0,
            32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 6, 1'b0);
        run(6'd0, 5'd4, 5'd9, 5'd0, 32'h0, 0,
            32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 6, 1'b0);
        run(6'd1, 5'd2, 5'd5, 5'd3, 32'h0BADF00D, 5,
            32'hDEADBEEF, 32'h1, 1'b1, 32'h0BADF00D, 1'b1, 11, 1'b0);

        done_en = 1'b0;
        run(6'd0, 5'd6, 5'd4, 5'd2, 32'h00000077, 0,
            32'h0BADF00D, 32'h0, 1'b1, 32'h77, 1'b0, 20, 1'b1);
        done_en = 1'b1;
        run(6'd0, 5'd8, 5'd0, 5'd6, 32'h00000005, 0,
            32'h77, 32'h0, 1'b1, 32'h5, 1'b1, 6, 1'b1);
        @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);
        @(posedge clk); #1;

        // Reset while waiting for the result abandons the instruction.
        e = '{32'h5, 32'h0BADF00D, 1'b1, 32'h0, 1'b1, 0, 16'd0, 1'b0};
        q.push_back(e);
        front(6'd0, 5'd1, 5'd2, 5'd8, 0);
        wait_neg(2, "rst_result");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        exp_cnt = '0;
        @(negedge clk);
        check("rst_mid_idle", {31'd0, inst_ready}, 32'd1);
        check("rst_mid_retire", {31'd0, retire}, 32'd0);
        check("rst_mid_cnt", {16'd0, retire_cnt}, 32'd0);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        run(6'd0, 5'd1, 5'd2, 5'd8, 32'h00000003, 0,
            32'h5, 32'h0BADF00D, 1'b1, 32'h3, 1'b1, 6, 1'b0);
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Initiator-side controller for the 32x32 register file's `set`/`wrt`/`done` handshake. It accepts one decoded instruction at a time and drives the RF through three steps: clear, operand read, then writeback or no-write completion. Read operands go to the execute unit, and the result returns over valid/ready handshakes. It sits between decode and execute in the fp_180b datapath and is the only block that drives the RF control inputs.

## Interface
Parameters:
- `TIMEOUT`, 15: max WRITE-state cycles waiting for `rf_done` before the error flag is set.
- `CNT_W`, 16: width of the retire counter.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_valid`  in  1  decode offers an instruction.
- `inst_ready`  out  1  sequencer accepts (IDLE only).
- `opcode`  in  6  instruction opcode.
- `rz`, `ry`, `rx`  in  5 each  destination, source Y, source X.
- `rf_set`, `rf_wrt`  out  1 each  RF control.
- `rf_opcode`  out  6  latched opcode to RF.
- `rf_rz`, `rf_ry`, `rf_rx`  out  5 each  latched register indices.
- `rf_data`  out  32  writeback data to RF.
- `rf_x`, `rf_y`  in  32 each  RF read ports.
- `rf_done`  in  1  RF completion, combinational from RF inputs.
- `opnd_valid`  out  1  operands offered to execute.
- `opnd_ready`  in  1  execute accepts operands.
- `op_a`, `op_b`  out  32 each  registered copies of `rf_x` and `rf_y`.
- `res_valid`  in  1  execute offers a result.
- `res_ready`  out  1  sequencer accepts the result.
- `res_data`  in  32  execute result.
- `retire`  out  1  one-cycle pulse when the instruction completes.
- `retire_cnt`  out  CNT_W  retired-instruction count; wraps.
- `err`  out  1  sticky; set on a `rf_done` timeout.

## Operation
- States: IDLE, SET, READ, ISSUE, RESULT, WRITE, RETIRE.
- IDLE
  - `inst_ready`=1.
  - On `inst_valid`: latch `opcode`/`rz`/`ry`/`rx`, then go to SET.
- SET: `rf_set`=1, `rf_wrt`=0. Go to READ next cycle unconditionally.
- READ: `rf_set`=0, `rf_wrt`=0. `op_a`<=`rf_x`, `op_b`<=`rf_y`. Go to ISSUE.
- ISSUE
  - `opnd_valid`=1; `op_a`/`op_b` stay stable while waiting.
  - On `opnd_ready`: go to RESULT.
- RESULT
  - `res_ready`=1.
  - On `res_valid`: latch `res_data` into the write register, then go to WRITE.
- WRITE
  - No-write opcodes (13, 14): `rf_wrt`=0.
  - All other opcodes: `rf_wrt`=1.
  - `rf_data` by opcode:
    - opcode 10 (upper-half load): `{16'h0, res[15:0]}`; the RF places the low 16 bits into `MEM[rz][31:16]`.
    - opcode 13 and 14: 0.
    - otherwise: the full 32-bit result.
  - Timer starts at 0 and increments each cycle.
  - `rf_done`=1 → RETIRE.
  - Timer == TIMEOUT-1 with no `rf_done` → set `err`, go to RETIRE.
- RETIRE: `retire`=1 for one cycle, `retire_cnt`++ (modulo 2^CNT_W), go to IDLE.
- `rz`==0 is not special-cased: `rf_wrt` is still asserted; the RF discards the write and still returns `rf_done`.
- `rf_*` index and opcode outputs are driven from the latched fields in every state, so they stay constant from SET through RETIRE.
- `rf_set`, `rf_wrt`, `opnd_valid`, `res_ready`, `inst_ready` and `retire` are decoded from the state register only.

## Timing
- Reset (`rst` high at a clock edge):
  - state, timer, `op_a`, `op_b`, latched fields, `retire_cnt` and `err` all go to 0, state to IDLE.
  - `inst_ready` is forced to 0 while `rst`=1; all other outputs are 0.
  - Reset mid-instruction abandons the instruction with no `retire`.
  - The RF contents are untouched.
- Zero-wait latency: accept in cycle 0 (IDLE), then SET c1, READ c2, ISSUE c3, RESULT c4, WRITE c5, RETIRE c6. IDLE again at c7, so the best-case throughput is one instruction per 7 cycles.
- `opnd_valid` and `res_ready` obey valid/ready: the transfer happens in the cycle both are high; neither is withdrawn before the transfer.
- `res_valid` arriving before RESULT is ignored, because `res_ready`=0 outside RESULT.
- `err` is sticky until `rst`. A timed-out instruction still retires and still increments `retire_cnt`.
- `retire_cnt` wraps from 2^CNT_W-1 to 0.

## Structure
- Shared package `fp180b_pkg`:
  - state enum;
  - opcode constants `OP_LUI`=10, `OP_NW0`=13, `OP_NW1`=14;
  - register-index width 5 and data width 32.
- One sub-module, `rf_wb_fmt`: combinational `rf_data` formatting from opcode and result. Everything else is flat.

## Test plan
- Reset, then write opcode 0 with `rz`=3 and result 0xDEADBEEF: `rf_wrt`=1 in c5, `rf_data`=0xDEADBEEF, `retire` in c6, `retire_cnt`=1. A second instruction with `rx`=3 returns `op_a`=0xDEADBEEF.
- Opcode 10 with result 0x12345678: `rf_data`=0x00005678. Reading the register back gives bits [31:16]=0x5678.
- Opcode 13: `rf_wrt` stays 0 throughout, `rf_done` is observed in WRITE, `retire` pulses, and no register changes.
- `rz`=0 with result 0xFFFFFFFF: the instruction retires, and a subsequent `rx`=0 read returns 0.
- `rf_done` stubbed to 0 with TIMEOUT=15: `err` rises after 15 WRITE cycles, then `retire` pulses, and `err` stays 1 until `rst`.
- Backpressure and reset:
  - `opnd_ready` held low 5 cycles: `op_a`/`op_b` stay stable and retire slips 5 cycles.
  - `rst` asserted in RESULT: next cycle IDLE, no `retire`, `retire_cnt` and `err` at 0.
